voice_mixer_seq: RTL and testbench

- Parametrised, time-multiplexed mixer for NUM_VOICES note_player voices.
- Snapshots all voice samples on a start request and applies a per-voice unsigned gain and a per-voice mute mask.
- Accumulates one voice per clock through a single multiplier, applies a master attenuation shift, and saturates the sum to signed 16-bit.
- Sits between the voice array and codec_conditioner, replacing the fixed 3-voice combinational saturating mixer. Adds gain, mute, clip counting and request queuing.

---
 rtl/voice_mixer_seq.sv | 200 ++++++++++++++++++++
 tb/tb_voice_mixer_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer_seq.sv
// Time-multiplexed voice mixer: snapshots all voices on a request, then runs one
// gain multiply per clock into a wide accumulator, attenuates, and saturates to 16 bits.
module voice_mixer_seq #(
  parameter int NUM_VOICES = 3,
  parameter int GAIN_W     = 8,
  parameter int SHIFT_W    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [16*NUM_VOICES-1:0]       voice_samples,
  input  logic [GAIN_W*NUM_VOICES-1:0]   voice_gain,
  input  logic [NUM_VOICES-1:0]          voice_active,
  input  logic [SHIFT_W-1:0]             master_shift,
  input  logic                           start,
  output logic                           busy,
  output logic signed [15:0]             sample_out,
  output logic                           sample_valid,
  output logic [15:0]                    clip_count,
  input  logic                           clear_clip,
  output logic                           overrun
);

  localparam int CLOG_N = $clog2(NUM_VOICES);
  localparam int ACC_W  = 16 + GAIN_W + CLOG_N + 1;
  localparam int PROD_W = 17 + GAIN_W;
  localparam int IDX_W  = (NUM_VOICES > 1) ? CLOG_N : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      pending_q, pending_d;
  logic signed [15:0]        out_q, out_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic [15:0]               clip_q, clip_d;
  logic                      overrun_q, overrun_d;
  logic                      snap_en_s;

  logic signed [15:0]        samp_q [NUM_VOICES];
  logic [GAIN_W-1:0]         gain_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]     act_q;
  logic [SHIFT_W-1:0]        shift_q;

  logic signed [PROD_W-1:0]  prod_s;
  logic signed [PROD_W-1:0]  prod_sh_s;
  logic signed [ACC_W-1:0]   term_s;
  logic signed [ACC_W-1:0]   res_s;
  logic signed [15:0]        sat_s;
  logic                      clip_s;

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    prod_s    = samp_q[idx_q] * $signed({1'b0, gain_q[idx_q]});
    prod_sh_s = prod_s >>> (GAIN_W - 1);
    if (act_q[idx_q]) begin
      term_s = ACC_W'(prod_sh_s);
    end else begin
      term_s = '0;
    end
  end

  always_comb begin
    res_s = acc_q >>> shift_q;
    if (res_s > SAT_MAX) begin
      sat_s  = 16'sh7FFF;
      clip_s = 1'b1;
    end else if (res_s < SAT_MIN) begin
      sat_s  = 16'sh8000;
      clip_s = 1'b1;
    end else begin
      sat_s  = res_s[15:0];
      clip_s = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;
    snap_en_s = 1'b0;
    clip_d    = clip_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_en_s = 1'b1;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = ACCUM;
        end else begin
          state_d   = IDLE;
        end
      end
      ACCUM: begin
        acc_d = acc_q + term_s;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
        // Only one request can be queued; a second one while queued is dropped.
        if (start) begin
          if (pending_q) begin
            overrun_d = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end else begin
          pending_d = pending_q;
        end
      end
      DONE: begin
        out_d   = sat_s;
        valid_d = 1'b1;
        if (start || pending_q) begin
          snap_en_s = 1'b1;
          pending_d = 1'b0;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = ACCUM;
        end else begin
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear_clip) begin
      clip_d = 16'h0000;
    end else if ((state_q == DONE) && clip_s && (clip_q != 16'hFFFF)) begin
      clip_d = clip_q + 16'h0001;
    end else begin
      clip_d = clip_q;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      out_q     <= 16'sh0000;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      clip_q    <= 16'h0000;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  // Snapshot isolates the running mix from input changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        samp_q[i] <= 16'sh0000;
        gain_q[i] <= '0;
      end
      act_q   <= '0;
      shift_q <= '0;
    end else if (snap_en_s) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        samp_q[i] <= voice_samples[16*i +: 16];
        gain_q[i] <= voice_gain[GAIN_W*i +: GAIN_W];
      end
      act_q   <= voice_active;
      shift_q <= master_shift;
    end else begin
      act_q   <= act_q;
      shift_q <= shift_q;
    end
  end

  assign busy         = busy_q;
  assign sample_out   = out_q;
  assign sample_valid = valid_q;
  assign clip_count   = clip_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_voice_mixer_seq.sv
// Directed-vector bench for voice_mixer_seq (3 voices, 8-bit gain) with
// hand-computed expected mixes, latency, queuing and reset behaviour.
module tb_voice_mixer_seq;

  logic               clk;
  logic               reset;
  logic [47:0]        voice_samples;
  logic [23:0]        voice_gain;
  logic [2:0]         voice_active;
  logic [2:0]         master_shift;
  logic               start;
  logic               busy;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic [15:0]        clip_count;
  logic               clear_clip;
  logic               overrun;

  int n_vec = 0;
  int n_bad = 0;

  voice_mixer_seq #(.NUM_VOICES(3), .GAIN_W(8), .SHIFT_W(3)) dut (
    .clk(clk), .reset(reset), .voice_samples(voice_samples), .voice_gain(voice_gain),
    .voice_active(voice_active), .master_shift(master_shift), .start(start),
    .busy(busy), .sample_out(sample_out), .sample_valid(sample_valid),
    .clip_count(clip_count), .clear_clip(clear_clip), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic signed [15:0] s0, s1, s2, input logic [7:0] g0, g1, g2,
                        input logic [2:0] act, input logic [2:0] sh);
    voice_samples = {s2, s1, s0};
    voice_gain    = {g2, g1, g0};
    voice_active  = act;
    master_shift  = sh;
  endtask

  // Pulses start for one edge (E0), then waits for the result and checks it.
  task automatic run_mix(input string tag, input int exp_out, input int exp_clip);
    int lat;
    lat   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'sd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (sample_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 32'sd4);
    chk({tag, "_out"}, sample_out, exp_out);
    chk({tag, "_clip"}, 32'(clip_count), exp_clip);
    chk({tag, "_idle"}, 32'(busy), 32'sd0);
    tick();
    chk({tag, "_vpulse"}, 32'(sample_valid), 32'sd0);
  endtask

  // Drives start per cycle from a mask; expects results at E4 and E8 only.
  task automatic run_queue(input string tag, input logic [12:0] smask, input logic [12:0] omask);
    int nv;
    nv = 0;
    set_in(16'sd1000, 16'sd2000, -16'sd500, 8'd128, 8'd128, 8'd128, 3'b111, 3'd0);
    for (int k = 0; k <= 12; k++) begin
      start = smask[k];
      if (k == 2) begin
        set_in(16'sd10, 16'sd20, 16'sd30, 8'd128, 8'd128, 8'd128, 3'b111, 3'd0);
      end
      tick();
      if (sample_valid) begin
        nv++;
      end
      if (k == 4) chk({tag, "_out1"}, sample_out, 32'sd2500);
      if (k == 8) chk({tag, "_out2"}, sample_out, 32'sd60);
      if (k == 3 || k == 4 || k == 8 || k == 9) begin
        chk({tag, "_valid"}, 32'(sample_valid), ((k == 4) || (k == 8)) ? 32'sd1 : 32'sd0);
      end
      chk({tag, "_ovr"}, 32'(overrun), 32'(omask[k]));
    end
    start = 1'b0;
    chk({tag, "_nres"}, nv, 32'sd2);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_clip = 1'b0;
    set_in(16'sd0, 16'sd0, 16'sd0, 8'd128, 8'd128, 8'd128, 3'b111, 3'd0);
    #12;
    chk("rst_out", sample_out, 32'sd0);
    chk("rst_valid", 32'(sample_valid), 32'sd0);
    chk("rst_busy", 32'(busy), 32'sd0);
    chk("rst_clip", 32'(clip_count), 32'sd0);
    chk("rst_ovr", 32'(overrun), 32'sd0);
    reset = 1'b0;
    tick();

    // Basic unity-gain mix
    set_in(16'sd1000, 16'sd2000, -16'sd500, 8'd128, 8'd128, 8'd128, 3'b111, 3'd0);
    run_mix("basic", 2500, 0);

    // Saturation both ways, then clear
    set_in(16'sd30000, 16'sd30000, 16'sd30000, 8'd128, 8'd128, 8'd128, 3'b111, 3'd0);
    run_mix("satpos", 32767, 1);
    set_in(-16'sd30000, -16'sd30000, -16'sd30000, 8'd128, 8'd128, 8'd128, 3'b111, 3'd0);
    run_mix("satneg", -32768, 2);
    clear_clip = 1'b1;
    tick();
    clear_clip = 1'b0;
    chk("clr_clip", 32'(clip_count), 32'sd0);

    // Gain and master shift
    set_in(16'sd16384, 16'sd7, 16'sd9, 8'd64, 8'd128, 8'd128, 3'b001, 3'd0);
    run_mix("gain64", 8192, 0);
    set_in(16'sd256, 16'sd7, 16'sd9, 8'd255, 8'd128, 8'd128, 3'b001, 3'd0);
    run_mix("gain255", 510, 0);
    set_in(16'sd256, 16'sd7, 16'sd9, 8'd255, 8'd128, 8'd128, 3'b001, 3'd1);
    run_mix("shift1", 255, 0);
    set_in(-16'sd3, 16'sd7, 16'sd9, 8'd128, 8'd128, 8'd128, 3'b001, 3'd1);
    run_mix("negshift", -2, 0);

    // Mute plus snapshot isolation: inputs change right after the start edge
    set_in(16'sd100, 16'sd200, 16'sd300, 8'd128, 8'd128, 8'd128, 3'b010, 3'd0);
    fork
      run_mix("mute", 200, 0);
      begin
        @(posedge clk);
        #2;
        set_in(16'sd5000, 16'sd5000, 16'sd5000, 8'd128, 8'd128, 8'd128, 3'b111, 3'd0);
      end
    join

    // Queuing: one queued request, then an extra one that overruns
    run_queue("q2", 13'b0_0000_0000_0101, 13'b0);
    run_queue("q3", 13'b0_0000_0000_1101, 13'b0_0000_0000_1000);

    // Async reset mid-accumulation
    set_in(16'sd30000, 16'sd30000, 16'sd30000, 8'd128, 8'd128, 8'd128, 3'b111, 3'd0);
    run_mix("preclip", 32767, 1);
    set_in(16'sd1000, 16'sd2000, -16'sd500, 8'd128, 8'd128, 8'd128, 3'b111, 3'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out", sample_out, 32'sd0);
    chk("arst_busy", 32'(busy), 32'sd0);
    chk("arst_clip", 32'(clip_count), 32'sd0);
    chk("arst_valid", 32'(sample_valid), 32'sd0);
    #1;
    reset = 1'b0;
    begin
      int nv;
      nv = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (sample_valid) nv++;
      end
      chk("arst_novalid", nv, 32'sd0);
    end
    run_mix("postrst", 2500, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
